// File: rtl/transmit_pkg.sv
// Shared UART definitions: SFR addresses, serial modes and TX states.
// Imported by both the transmitter and the receiver.
package transmit_pkg;

   localparam logic [7:0] SBUF_RX = 8'h98;
   localparam logic [7:0] SBUF_TX = 8'h99;

   typedef enum logic [1:0] {
      MODE_SHIFT = 2'b00,
      MODE_UART8 = 2'b01,
      MODE_UART9 = 2'b10,
      MODE_UART9V = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      NINTH = 3'd3,
      STOP  = 3'd4
   } tx_state_e;

endpackage

// File: rtl/transmit_if.sv
// SFR write port, baud ticks and serial outputs of the UART transmitter.
// master drives the bus side, slave is the transmitter.
interface transmit_if;
   logic [7:0] AB;
   logic [7:0] din;
   logic       wr_n;
   logic [1:0] SM;
   logic       TB8;
   logic       TC;
   logic       T7;
   logic       TxD;
   logic       shclk;
   logic       TI;
   logic       busy;

   modport master (
      output AB, din, wr_n, SM, TB8, TC, T7,
      input  TxD, shclk, TI, busy
   );

   modport slave (
      input  AB, din, wr_n, SM, TB8, TC, T7,
      output TxD, shclk, TI, busy
   );
endinterface

// File: rtl/transmit.sv
// UART transmitter: mode-0 shift register and 8/9-bit async frames.
// TxD is registered from the next-state view so it tracks state exactly.
module transmit
   import transmit_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   transmit_if.slave bus
);

   tx_state_e  state, state_n;
   logic [7:0] sr, sr_n;
   logic [2:0] cnt, cnt_n;
   logic [3:0] timer, timer_n;
   mode_e      mode, mode_n;
   logic       tb8, tb8_n;
   logic       txd, txd_n;
   logic       upd, upd_n;
   logic       shclk;
   logic       ti, ti_n;
   logic       wr_ok, wrap, step, shift_mode;

   assign shift_mode = (mode == MODE_SHIFT);
   assign wr_ok = !bus.wr_n && (bus.AB == SBUF_TX) && (state == IDLE);
   assign wrap  = bus.TC && (timer == 4'hF);
   assign step  = shift_mode ? bus.T7 : wrap;

   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = cnt;
      mode_n  = mode;
      tb8_n   = tb8;
      upd_n   = 1'b0;
      ti_n    = 1'b0;
      timer_n = timer;
      if (state != IDLE && bus.TC)
         timer_n = timer + 4'd1;
      unique case (state)
         IDLE: begin
            if (wr_ok) begin
               sr_n    = bus.din;
               cnt_n   = 3'd0;
               timer_n = 4'd0;
               mode_n  = mode_e'(bus.SM);
               tb8_n   = bus.TB8;
               if (mode_e'(bus.SM) == MODE_SHIFT) begin
                  state_n = DATA;
                  upd_n   = 1'b1;
               end else begin
                  state_n = START;
               end
            end
         end
         START: if (wrap) state_n = DATA;
         DATA: begin
            if (step) begin
               sr_n  = {1'b0, sr[7:1]};
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  if (shift_mode) begin
                     state_n = IDLE;
                     ti_n    = 1'b1;
                  end else if (mode == MODE_UART8) begin
                     state_n = STOP;
                  end else begin
                     state_n = NINTH;
                  end
               end else begin
                  upd_n = shift_mode;
               end
            end
         end
         NINTH: if (wrap) state_n = STOP;
         STOP: begin
            if (wrap) begin
               state_n = IDLE;
               ti_n    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      txd_n = 1'b1;
      unique case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = sr_n[0];
         NINTH:   txd_n = tb8_n;
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= 8'd0;
         cnt   <= 3'd0;
         timer <= 4'd0;
         mode  <= MODE_UART8;
         tb8   <= 1'b0;
         txd   <= 1'b1;
         upd   <= 1'b0;
         shclk <= 1'b0;
         ti    <= 1'b0;
      end else begin
         state <= state_n;
         sr    <= sr_n;
         cnt   <= cnt_n;
         timer <= timer_n;
         mode  <= mode_n;
         tb8   <= tb8_n;
         txd   <= txd_n;
         upd   <= upd_n;
         shclk <= upd;
         ti    <= ti_n;
      end
   end

   assign bus.TxD   = txd;
   assign bus.shclk = shclk;
   assign bus.TI    = ti;
   assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_transmit.sv
// Bench for the UART transmitter: queue-based frame model checked every
// cycle, plus literal bit-sequence and tick-count expectations.
module tb_transmit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   transmit_if bus ();

   transmit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame model: the list of line bits still to send and ticks left on
   // the current bit.
   bit   q[$];
   bit   m_busy = 1'b0;
   bit   m_txd  = 1'b1;
   bit   m_ti   = 1'b0;
   bit   m_sh   = 1'b0;
   bit   pend   = 1'b0;
   bit   m_t7   = 1'b0;
   int   tleft  = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 1'b0; m_txd = 1'b1; m_ti = 1'b0;
            m_sh = 1'b0; pend = 1'b0; q.delete();
         end else begin
            m_ti = 1'b0;
            m_sh = pend;
            pend = 1'b0;
            if (m_busy) begin
               if (m_t7 ? bus.T7 : bus.TC) begin
                  tleft--;
                  if (tleft == 0) begin
                     void'(q.pop_front());
                     if (q.size() == 0) begin
                        m_busy = 1'b0; m_ti = 1'b1; m_txd = 1'b1;
                     end else begin
                        m_txd = q[0];
                        tleft = m_t7 ? 1 : 16;
                        pend  = m_t7;
                     end
                  end
               end
            end else if (!bus.wr_n && bus.AB == 8'h99) begin
               m_t7 = (bus.SM == 2'b00);
               q.delete();
               if (!m_t7) q.push_back(1'b0);
               for (int i = 0; i < 8; i++) q.push_back(bus.din[i]);
               if (bus.SM[1]) q.push_back(bus.TB8);
               if (!m_t7) q.push_back(1'b1);
               m_txd  = q[0];
               tleft  = m_t7 ? 1 : 16;
               m_busy = 1'b1;
               pend   = m_t7;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("TxD", 32'(bus.TxD), 32'(m_txd));
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("TI", 32'(bus.TI), 32'(m_ti));
         chk("shclk", 32'(bus.shclk), 32'(m_sh));
      end
   end

   task automatic sbuf_wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.AB = a; bus.din = d; bus.wr_n = 1'b0;
   endtask

   // Tick the frame along until TI; sample mid-bit (UART) or on shclk.
   task automatic run(input bit t7m, input int wr_at, input int rst_at,
                      input bit chain, output int nt,
                      output logic [10:0] seq, output int nsmp,
                      output int xti);
      int done = 0;
      int cyc = 0;
      bit last = 1'b0;
      bit wrote = 1'b0;
      nt = -1; seq = '0; nsmp = 0; xti = 0;
      while (nt < 0 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         bus.wr_n = 1'b1;
         if (last) done++;
         if (t7m ? bus.shclk : (last && done % 16 == 8)) begin
            seq = {seq[9:0], bus.TxD};
            nsmp++;
         end
         if (bus.TI) begin
            nt = done;
            last = 1'b0;
            bus.TC = 1'b0; bus.T7 = 1'b0;
            if (chain) begin
               bus.AB = 8'h99; bus.din = 8'h55; bus.wr_n = 1'b0;
            end
         end else begin
            if (last && done == rst_at) begin
               bus.TC = 1'b0; bus.T7 = 1'b0;
               #1 rst_n = 1'b0;
               @(negedge clk);
               chk("rst_TxD", 32'(bus.TxD), 32'd1);
               chk("rst_busy", 32'(bus.busy), 32'd0);
               chk("rst_TI", 32'(bus.TI), 32'd0);
               rst_n = 1'b1;
               return;
            end
            if (last && done == wr_at && !wrote) begin
               wrote = 1'b1;
               bus.AB = 8'h99; bus.din = 8'hFF; bus.wr_n = 1'b0;
               bus.SM = ~bus.SM; bus.TB8 = ~bus.TB8;
            end
            last = t7m ? (cyc % 12 == 0) : (cyc % 4 == 0);
            if (t7m) bus.T7 = last;
            else bus.TC = last;
         end
      end
      if (nt < 0) begin
         chk("frame_timeout", 32'(cyc), 32'd0);
         return;
      end
      if (!chain) begin
         repeat (40) begin
            @(negedge clk);
            bus.wr_n = 1'b1;
            if (bus.TI) xti++;
         end
      end
   endtask

   int nt, nsmp, xti;
   logic [10:0] seq;

   initial begin
      bus.AB = 8'h00; bus.din = 8'h00; bus.wr_n = 1'b1;
      bus.SM = 2'b01; bus.TB8 = 1'b0; bus.TC = 1'b0; bus.T7 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_TxD", 32'(bus.TxD), 32'd1);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_TI", 32'(bus.TI), 32'd0);
      chk("reset_shclk", 32'(bus.shclk), 32'd0);
      rst_n = 1'b1;
      cmp_on = 1'b1;

      sbuf_wr(8'h98, 8'h12);
      @(negedge clk); bus.wr_n = 1'b1;
      @(negedge clk);
      chk("rx_addr_ignored", 32'(bus.busy), 32'd0);

      bus.SM = 2'b01;
      sbuf_wr(8'h99, 8'hA5);
      run(1'b0, -1, -1, 1'b0, nt, seq, nsmp, xti);
      chk("a5_ticks", 32'(nt), 32'd160);
      chk("a5_bits", 32'(seq), 32'b00101001011);
      chk("a5_extra_ti", 32'(xti), 32'd0);

      bus.SM = 2'b11; bus.TB8 = 1'b1;
      sbuf_wr(8'h99, 8'h3C);
      run(1'b0, -1, -1, 1'b0, nt, seq, nsmp, xti);
      chk("3c_ticks", 32'(nt), 32'd176);
      chk("3c_bits", 32'(seq), 32'b00011110011);
      chk("3c_nbits", 32'(nsmp), 32'd11);

      bus.SM = 2'b00; bus.TB8 = 1'b0;
      sbuf_wr(8'h99, 8'h81);
      run(1'b1, -1, -1, 1'b0, nt, seq, nsmp, xti);
      chk("m0_ticks", 32'(nt), 32'd8);
      chk("m0_bits", 32'(seq), 32'b00010000001);
      chk("m0_shclk", 32'(nsmp), 32'd8);

      bus.SM = 2'b01; bus.TB8 = 1'b0;
      sbuf_wr(8'h99, 8'hA5);
      run(1'b0, 50, -1, 1'b0, nt, seq, nsmp, xti);
      chk("busy_wr_ticks", 32'(nt), 32'd160);
      chk("busy_wr_bits", 32'(seq), 32'b00101001011);
      chk("busy_wr_one_ti", 32'(xti), 32'd0);

      bus.SM = 2'b01; bus.TB8 = 1'b0;
      sbuf_wr(8'h99, 8'hA5);
      run(1'b0, -1, 88, 1'b0, nt, seq, nsmp, xti);
      repeat (20) @(negedge clk);
      sbuf_wr(8'h99, 8'hC3);
      run(1'b0, -1, -1, 1'b0, nt, seq, nsmp, xti);
      chk("post_rst_ticks", 32'(nt), 32'd160);
      chk("post_rst_bits", 32'(seq), 32'b00110000111);

      sbuf_wr(8'h99, 8'h0F);
      run(1'b0, -1, -1, 1'b1, nt, seq, nsmp, xti);
      chk("chain1_ticks", 32'(nt), 32'd160);
      chk("chain1_bits", 32'(seq), 32'b00111100001);
      @(negedge clk);
      bus.wr_n = 1'b1;
      chk("chain_start_TxD", 32'(bus.TxD), 32'd0);
      chk("chain_start_busy", 32'(bus.busy), 32'd1);
      run(1'b0, -1, -1, 1'b0, nt, seq, nsmp, xti);
      chk("chain2_ticks", 32'(nt), 32'd160);
      chk("chain2_bits", 32'(seq), 32'b00101010101);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
